// File: rtl/m_store_buffer.sv
// Posted-write store buffer: queues M-stage stores and drains them in order over mem_req/mem_ack.
// Optional build macro STORE_MERGE_EN folds a store into the tail entry when it hits the same word.
module m_store_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [3:0]       st_byteen,
    input  logic [31:0]      st_wdata,
    input  logic [31:0]      st_pc,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    output logic             stall,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_byteen,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [29:0]      addr_q [DEPTH];
    logic [3:0]       be_q   [DEPTH];
    logic [31:0]      wd_q   [DEPTH];
    logic [31:0]      pc_q   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic cand, full, pop, push, merge, hit;

    assign cand = st_valid && (st_byteen != 4'b0000);
    assign full = (count_q == FULL);
    assign pop  = (count_q != '0) && mem_ack;

`ifdef STORE_MERGE_EN
    logic [PTR_W-1:0] last_ptr;
    assign last_ptr = tail_q - PTR_W'(1);
    // count >= 2 guarantees the tail-most entry is never the head on the memory port
    assign merge = cand && (count_q >= CNT_W'(2)) && (addr_q[last_ptr] == st_addr[31:2]);
`else
    assign merge = 1'b0;
`endif

    assign push  = cand && !merge && (!full || pop);
    assign stall = (cand && full && !pop && !merge) || (ld_valid && !st_valid && hit);

    always_comb begin
        logic [PTR_W-1:0] offset;
        hit    = 1'b0;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - head_q;
            if ((CNT_W'(offset) < count_q) && (addr_q[i] == ld_addr[31:2]))
                hit = 1'b1;
        end
    end

    always_comb begin
        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload carries no reset; occupancy is defined solely by head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= st_addr[31:2];
            be_q[tail_q]   <= st_byteen;
            wd_q[tail_q]   <= st_wdata;
            pc_q[tail_q]   <= st_pc;
        end
`ifdef STORE_MERGE_EN
        if (merge) begin
            be_q[last_ptr] <= be_q[last_ptr] | st_byteen;
            for (int b = 0; b < 4; b++) begin
                if (st_byteen[b])
                    wd_q[last_ptr][8*b +: 8] <= st_wdata[8*b +: 8];
            end
        end
`endif
    end

    assign mem_req    = (count_q != '0);
    assign mem_addr   = {addr_q[head_q], 2'b00};
    assign mem_byteen = be_q[head_q];
    assign mem_wdata  = wd_q[head_q];
    assign count      = count_q;
    assign empty      = (count_q == '0);

    // Head PC is retained for the write log; byte-offset bits carry no meaning for a word buffer.
    logic unused_log;
    assign unused_log = ^{st_addr[1:0], ld_addr[1:0], pc_q[head_q]};

endmodule

// File: tb/tb_m_store_buffer.sv
// Directed self-checking bench for m_store_buffer (DEPTH=4), with expectations for either STORE_MERGE_EN build.
module tb_m_store_buffer;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [3:0]  st_byteen;
    logic [31:0] st_wdata;
    logic [31:0] st_pc;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [2:0]  count;
    logic        empty;

    int vectors;
    int miscompares;

    m_store_buffer #(.DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_byteen(st_byteen),
        .st_wdata(st_wdata), .st_pc(st_pc),
        .ld_valid(ld_valid), .ld_addr(ld_addr),
        .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_byteen(mem_byteen), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .count(count), .empty(empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        st_valid  = 1'b1;
        st_addr   = a;
        st_byteen = be;
        st_wdata  = d;
        st_pc     = a + 32'h0000_0400;
        tick();
        st_valid  = 1'b0;
        st_byteen = 4'b0000;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset     = 1'b0;
        st_valid  = 1'b0;
        st_addr   = '0;
        st_byteen = '0;
        st_wdata  = '0;
        st_pc     = '0;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        mem_ack   = 1'b0;

        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_req",   32'(mem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        #1 reset = 1'b1;

        // single store, ack held off for three cycles
        st_valid = 1'b1; st_addr = 32'h0000_1004; st_byteen = 4'b1111;
        st_wdata = 32'hDEAD_BEEF; st_pc = 32'h0000_0100;
        #1;
        chk("st1_pre_req", 32'(mem_req), 32'd0);
        tick();
        st_valid = 1'b0; st_byteen = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            chk("st1_req",   32'(mem_req), 32'd1);
            chk("st1_addr",  mem_addr, 32'h0000_1004);
            chk("st1_be",    32'(mem_byteen), 32'hF);
            chk("st1_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("st1_count", 32'(count), 32'd1);
            if (k < 3) tick();
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("st1_empty", 32'(empty), 32'd1);
        chk("st1_req_off", 32'(mem_req), 32'd0);

        // fill to DEPTH, fifth store stalls until an ack frees a slot
        store(32'h0000_0100, 4'b1111, 32'h1111_0000);
        store(32'h0000_0104, 4'b1111, 32'h1111_0001);
        store(32'h0000_0108, 4'b1111, 32'h1111_0002);
        store(32'h0000_010C, 4'b1111, 32'h1111_0003);
        chk("fill_count", 32'(count), 32'd4);
        st_valid = 1'b1; st_addr = 32'h0000_0110; st_byteen = 4'b1111; st_wdata = 32'h1111_0004;
        #1;
        chk("full_stall", 32'(stall), 32'd1);
        tick();
        chk("full_stall_hold", 32'(stall), 32'd1);
        chk("full_count_hold", 32'(count), 32'd4);
        mem_ack = 1'b1;
        #1;
        chk("full_pushpop_stall", 32'(stall), 32'd0);
        tick();
        st_valid = 1'b0; st_byteen = 4'b0000;
        chk("pushpop_count", 32'(count), 32'd4);
        chk("drain_addr0", mem_addr, 32'h0000_0104);
        tick();
        chk("drain_addr1", mem_addr, 32'h0000_0108);
        chk("drain_count1", 32'(count), 32'd3);
        tick();
        chk("drain_addr2", mem_addr, 32'h0000_010C);
        tick();
        chk("drain_addr3", mem_addr, 32'h0000_0110);
        chk("drain_wdata3", mem_wdata, 32'h1111_0004);
        chk("drain_count3", 32'(count), 32'd1);
        tick();
        mem_ack = 1'b0;
        chk("drain_empty", 32'(empty), 32'd1);

        // load-after-store hazard
        store(32'h0000_2000, 4'b1111, 32'h2222_2222);
        store(32'h0000_3000, 4'b0011, 32'h3333_3333);
        ld_valid = 1'b1; ld_addr = 32'h0000_2003;
        #1;
        chk("ld_hit_head", 32'(stall), 32'd1);
        tick();
        chk("ld_hit_hold", 32'(stall), 32'd1);
        ld_addr = 32'h0000_2004;
        #1;
        chk("ld_miss", 32'(stall), 32'd0);
        ld_addr = 32'h0000_3001;
        #1;
        chk("ld_hit_tail", 32'(stall), 32'd1);
        ld_addr = 32'h0000_2003;
        st_valid = 1'b1; st_addr = 32'h0000_5000; st_byteen = 4'b0000; st_wdata = 32'h5;
        #1;
        chk("ld_store_prio", 32'(stall), 32'd0);
        tick();
        st_valid = 1'b0;
        chk("be0_count", 32'(count), 32'd2);
        chk("be0_req", 32'(mem_req), 32'd1);
        chk("be0_head", mem_addr, 32'h0000_2000);
        mem_ack = 1'b1;
        #1;
        chk("ld_hit_ack_cycle", 32'(stall), 32'd1);
        tick();
        mem_ack = 1'b0;
        chk("ld_release", 32'(stall), 32'd0);
        chk("ld_next_head", mem_addr, 32'h0000_3000);
        chk("ld_next_be", 32'(mem_byteen), 32'h3);
        ld_valid = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("ld_drained", 32'(empty), 32'd1);

        // same-word stores: merged into the tail only when STORE_MERGE_EN is built in
        store(32'h0000_0010, 4'b0001, 32'h0000_0011);
        store(32'h0000_0020, 4'b1111, 32'hAAAA_BBBB);
        store(32'h0000_0022, 4'b1100, 32'h5555_5555);
`ifdef STORE_MERGE_EN
        chk("merge_count", 32'(count), 32'd2);
`else
        chk("nomerge_count", 32'(count), 32'd3);
`endif
        chk("merge_head_addr", mem_addr, 32'h0000_0010);
        chk("merge_head_be", 32'(mem_byteen), 32'h1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("merge_second_addr", mem_addr, 32'h0000_0020);
        chk("merge_second_be", 32'(mem_byteen), 32'hF);
`ifdef STORE_MERGE_EN
        chk("merge_second_wdata", mem_wdata, 32'h5555_BBBB);
        chk("merge_after_count", 32'(count), 32'd1);
        store(32'h0000_0040, 4'b1111, 32'h4444_4444);
`else
        chk("nomerge_second_wdata", mem_wdata, 32'hAAAA_BBBB);
        chk("nomerge_after_count", 32'(count), 32'd2);
`endif
        store(32'h0000_0030, 4'b1111, 32'h3030_3030);
        chk("prerst_count", 32'(count), 32'd3);
        chk("prerst_req", 32'(mem_req), 32'd1);

        // asynchronous reset mid-handshake
        #2 reset = 1'b0;
        #1;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_stall", 32'(stall), 32'd0);
        #1 reset = 1'b1;
        tick();
        chk("post_rst_empty", 32'(empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
